// File: rtl/nibble_adder_seq_if.sv
// nibble_adder_seq_if: operand request and result handshake bundle for nibble_adder_seq
// Ports: in_valid/in_ready/a/b/cin/sub carry the request; out_valid/out_ready/sum/cout carry the result.
// master = operand source plus result consumer, slave = the adder.
interface nibble_adder_seq_if #(parameter int W = 16);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout
   );
   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout
   );
endinterface

// File: rtl/nibble_adder_seq.sv
// nibble_adder_seq: nibble-serial adder/subtractor sharing one 4-bit add stage over four cycles
// Ports: clk, rst_n (async active-low); bus = request/result handshake (slave side); busy = not IDLE.
module nibble_adder_seq #(
   parameter int NIB_W = 4,
   parameter int N_NIB = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   nibble_adder_seq_if.slave   bus,
   output logic                busy
);
   localparam int W = NIB_W * N_NIB;
   localparam int CW = (N_NIB > 1) ? $clog2(N_NIB) : 1;
   localparam logic [CW-1:0] LAST = CW'(N_NIB - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nxt;
   logic [W-1:0] a_r, b_r, sum_r;
   logic carry, cout_r;
   logic [CW-1:0] cnt;
   logic [NIB_W-1:0] a_nib, b_nib, s_nib;
   logic c_nib;
   assign a_nib = a_r[cnt*NIB_W +: NIB_W];
   assign b_nib = b_r[cnt*NIB_W +: NIB_W];
   assign {c_nib, s_nib} = {1'b0, a_nib} + {1'b0, b_nib} + (NIB_W+1)'(carry);
   assign bus.sum = sum_r;
   assign bus.cout = cout_r;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   // The unused encoding falls back to IDLE.
   always_comb begin
      state_nxt = (state == RUN || state == DONE) ? state : IDLE;
      if (state == IDLE && bus.in_valid) state_nxt = RUN;
      if (state == RUN && cnt == LAST) state_nxt = DONE;
      if (state == DONE && bus.out_ready) state_nxt = IDLE;
      bus.in_ready = state == IDLE;
      bus.out_valid = state == DONE;
      busy = state != IDLE;
   end
   // Subtraction is a + ~b + 1, so the mode is folded into b_r and carry at capture.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         a_r <= '0;
         b_r <= '0;
         carry <= 1'b0;
         cnt <= '0;
         sum_r <= '0;
         cout_r <= 1'b0;
      end else if (state == IDLE && bus.in_valid) begin
         a_r <= bus.a;
         b_r <= bus.sub ? ~bus.b : bus.b;
         carry <= bus.sub | bus.cin;
         cnt <= '0;
      end else if (state == RUN) begin
         sum_r[cnt*NIB_W +: NIB_W] <= s_nib;
         carry <= c_nib;
         cnt <= cnt + 1'b1;
         if (cnt == LAST) cout_r <= c_nib;
      end
endmodule

// File: tb/tb_nibble_adder_seq.sv
// tb_nibble_adder_seq: directed self-checking bench for nibble_adder_seq
module tb_nibble_adder_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic busy;
   int checks = 0;
   int errors = 0;
   nibble_adder_seq_if bus ();
   nibble_adder_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy(busy));
   always #5 clk = ~clk;

   // Issue one request from IDLE (called at posedge+1) and wait, bounded, for out_valid.
   task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                         input logic is, output int lat);
      bus.a = ia;
      bus.b = ib;
      bus.cin = ic;
      bus.sub = is;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 99;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic release_op();
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.cin = 1'b0;
      bus.sub = 1'b0;
      #3 rst_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b want 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", bus.out_valid); end
      checks++; if ({bus.cout, bus.sum} !== 17'h0) begin errors++; $display("FAIL reset cout/sum got %h want 00000", {bus.cout, bus.sum}); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      bus.a = 16'hC3FF;
      bus.b = 16'h0001;
      bus.cin = 1'b0;
      bus.sub = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         checks++; if (bus.out_valid !== (i == 4)) begin errors++; $display("FAIL add latency edge %0d out_valid got %b want %b", i, bus.out_valid, i == 4); end
         checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL add busy edge %0d busy/in_ready got %b%b want 10", i, busy, bus.in_ready); end
      end
      checks++; if ({bus.cout, bus.sum} !== {1'b0, 16'hC400}) begin errors++; $display("FAIL add result got %h want 0c400", {bus.cout, bus.sum}); end
      release_op();
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL add handshake out_valid/in_ready got %b%b want 01", bus.out_valid, bus.in_ready); end
   endtask

   task automatic test_carry();
      int lat;
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL ripple latency got %0d want 4", lat); end
      checks++; if ({bus.cout, bus.sum} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL ripple result got %h want 10000", {bus.cout, bus.sum}); end
      release_op();
      run_op(16'h00FF, 16'h0000, 1'b1, 1'b0, lat);
      checks++; if ({bus.cout, bus.sum} !== {1'b0, 16'h0100}) begin errors++; $display("FAIL cin result got %h want 00100", {bus.cout, bus.sum}); end
      release_op();
   endtask

   task automatic test_sub();
      int lat;
      for (int c = 0; c < 2; c++) begin
         run_op(16'h1000, 16'h0001, c[0], 1'b1, lat);
         checks++; if ({bus.cout, bus.sum} !== {1'b1, 16'h0FFF}) begin errors++; $display("FAIL sub no-borrow cin=%0d got %h want 10fff", c, {bus.cout, bus.sum}); end
         release_op();
         run_op(16'h0000, 16'h0001, c[0], 1'b1, lat);
         checks++; if ({bus.cout, bus.sum} !== {1'b0, 16'hFFFF}) begin errors++; $display("FAIL sub borrow cin=%0d got %h want 0ffff", c, {bus.cout, bus.sum}); end
         release_op();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      run_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
      bus.a = 16'h1111;
      bus.b = 16'h1111;
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = i[0];
         @(posedge clk); #1;
         checks++; if ({bus.out_valid, bus.in_ready, bus.cout, bus.sum} !== {3'b100, 16'h2345}) begin
            errors++; $display("FAIL backpressure cycle %0d valid/ready/cout/sum got %b%b%b %h want 100 2345", i, bus.out_valid, bus.in_ready, bus.cout, bus.sum);
         end
      end
      bus.in_valid = 1'b0;
      release_op();
      checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sum !== 16'h2345) begin
         errors++; $display("FAIL backpressure release ready/valid/sum got %b%b %h want 10 2345", bus.in_ready, bus.out_valid, bus.sum);
      end
      run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, lat);
      checks++; if (lat !== 4 || {bus.cout, bus.sum} !== {1'b0, 16'h1000}) begin errors++; $display("FAIL backpressure next op lat %0d result got %h want 4 01000", lat, {bus.cout, bus.sum}); end
      release_op();
   endtask

   task automatic test_stability();
      int lat = 99;
      bus.a = 16'h1234;
      bus.b = 16'h4321;
      bus.cin = 1'b0;
      bus.sub = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         bus.a = 16'($urandom);
         bus.b = 16'($urandom);
         bus.cin = 1'b1;
         bus.sub = 1'b1;
         @(posedge clk); #1;
         if (bus.out_valid) begin
            lat = i;
            break;
         end
      end
      checks++; if (lat !== 4 || {bus.cout, bus.sum} !== {1'b0, 16'h5555}) begin errors++; $display("FAIL stability lat %0d result got %h want 4 05555", lat, {bus.cout, bus.sum}); end
      bus.sub = 1'b0;
      bus.cin = 1'b0;
      release_op();
   endtask

   task automatic test_reset_mid();
      int lat;
      bus.a = 16'h1111;
      bus.b = 16'h2222;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++; if ({bus.out_valid, bus.in_ready, busy, bus.cout, bus.sum} !== {4'b0100, 16'h0000}) begin
         errors++; $display("FAIL mid reset valid/ready/busy/cout/sum got %b%b%b%b %h want 0100 0000", bus.out_valid, bus.in_ready, busy, bus.cout, bus.sum);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(16'h0001, 16'h0002, 1'b0, 1'b0, lat);
      checks++; if (lat !== 4 || {bus.cout, bus.sum} !== {1'b0, 16'h0003}) begin errors++; $display("FAIL after reset lat %0d result got %h want 4 00003", lat, {bus.cout, bus.sum}); end
      release_op();
   endtask

   initial begin
      test_reset();
      test_add();
      test_carry();
      test_sub();
      test_backpressure();
      test_stability();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/nibble_adder_seq.md
Name: nibble_adder_seq

Overview:
- Nibble-serial 16-bit adder/subtractor controller.
- Captures two 16-bit operands through a valid/ready handshake and splits each into four 4-bit nibbles, out0 (bits 3:0) through out3 (bits 15:12).
- Time-shares one internal 4-bit add stage across those nibbles over four cycles, chaining the carry.
- Presents the 16-bit result and carry-out through an output valid/ready handshake; sits between an operand source and a result consumer in the adder test datapath.

Parameters:
- NIB_W, 4, nibble width in bits.
- N_NIB, 4, number of nibbles; operand width = NIB_W*N_NIB = 16.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand source has a valid request.
- in_ready  output  1  block can accept a request.
- a  input  16  operand A.
- b  input  16  operand B.
- cin  input  1  carry-in for add mode; ignored when sub=1.
- sub  input  1  0 = a+b+cin, 1 = a-b.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  16  result.
- cout  output  1  carry-out; in sub mode 1 = no borrow.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, nibble counter=0, in_ready=1, out_valid=0, sum=0, cout=0, busy=0. Internal operand, carry and mode registers are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1, the block registers a, b, sub and the initial carry, then goes to RUN with cnt=0.
  - Add mode: registered B = b; initial carry = cin.
  - Sub mode: registered B = ~b; initial carry = 1.
- RUN: in_ready=0, busy=1. Each edge handles nibble cnt:
  - computes {c, s} = A_nib[cnt] + B_nib[cnt] + carry (5-bit result);
  - writes s into sum[4*cnt+3:4*cnt] and stores c as the next carry;
  - increments cnt.
  - On the edge where cnt=3: cout takes the final carry, out_valid goes to 1 and the state goes to DONE.
- Latency: out_valid rises on the 4th rising edge after the accepting edge.
- Operand, cin and sub inputs are ignored outside the accepting edge; changes during RUN/DONE have no effect.
- DONE: out_valid=1, in_ready=0. sum and cout are held stable until handshake.
  - On an edge with out_ready=1: out_valid goes to 0 and the state returns to IDLE.
  - sum and cout keep their last value until the next RUN overwrites them.
- No overlap: a new request can be accepted at the earliest one edge after the output handshake. Minimum period is 6 cycles per operation.
- in_valid pulses arriving while in_ready=0 are ignored; they are not queued.
- out_ready asserted outside DONE has no effect.
- Reset asserted mid-RUN or mid-DONE: the operation is discarded immediately and all outputs return to reset values. After release, the block accepts a new request normally.
- Arithmetic is modulo 2^16; overflow is reported only through cout. There is no signed-overflow flag.

Test Plan:
- Add: a=16'hC3FF, b=16'h0001, cin=0, sub=0 -> sum=16'hC400, cout=0; out_valid high exactly 4 edges after the accepting edge; busy=1 throughout RUN.
- Full carry ripple: a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1. Also a=16'h00FF, b=16'h0000, cin=1 -> sum=16'h0100, cout=0.
- Subtract:
  - a=16'h1000, b=16'h0001, sub=1 -> sum=16'h0FFF, cout=1.
  - a=16'h0000, b=16'h0001, sub=1 -> sum=16'hFFFF, cout=0.
  - cin=1 with sub=1 has no effect on either case.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> sum, cout and out_valid stay stable and in_ready=0; in_valid pulsed with a=16'h1111 is not accepted. Raise out_ready -> IDLE next edge, then a new op completes correctly.
- Input stability: change a and b every cycle during RUN -> result equals the values captured at the accepting edge.
- Reset mid-operation: assert rst_n=0 two edges into RUN -> out_valid=0, sum=0, cout=0, in_ready=1 immediately. After release, a=16'h0001, b=16'h0002 -> sum=16'h0003, cout=0.
